// File: rtl/pn_counter_n_if.sv
// Control/status bundle for pn_counter_n: master drives the controls, slave returns the state.
interface pn_counter_n_if #(parameter int WIDTH = 4);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (output en, load, load_val, mode, input  count, tc, wrap);
  modport slave  (input  en, load, load_val, mode, output count, tc, wrap);
endinterface

// File: rtl/pn_counter_n.sv
// N-bit up/down/Gray counter whose state bits are PN flip-flops (next = P&~Q | N&Q).
// A shared comb block picks the target value; each bit turns it into its own P/N pair.
module pn_flop (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_p,
  input  logic i_n,
  output logic o_q
);
  always_ff @(posedge i_clk) begin
    if (i_reset) o_q <= 1'b0;
    else         o_q <= (i_p & ~o_q) | (i_n & o_q);
  end
endmodule

module pn_counter_n #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter int SATURATE = 0
) (
  input  logic clk,
  input  logic reset,
  pn_counter_n_if.slave bus
);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONES   = '1;
  localparam logic [WIDTH-1:0] G_LAST = ONES ^ (ONES >> 1);
  localparam bit               SAT    = (SATURATE != 0);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] w_q, w_tgt, w_p, w_n, w_bin;
  logic             w_wrap_nxt, w_over;
  logic             r_wrap;

  assign w_bin  = gray2bin(w_q);
  assign w_over = ({1'b0, w_q} >= MOD_W);

  always_comb begin
    w_tgt      = w_q;
    w_wrap_nxt = 1'b0;
    if (bus.load) begin
      w_tgt = ({1'b0, bus.load_val} >= MOD_W) ? MAX : bus.load_val;
    end else if (bus.en) begin
      case (bus.mode)
        2'b00: begin
          if (w_over)            w_tgt = '0;
          else if (w_q == MAX) begin
            if (!SAT) begin w_tgt = '0; w_wrap_nxt = 1'b1; end
          end else               w_tgt = w_q + WIDTH'(1);
        end
        2'b01: begin
          if (w_over)            w_tgt = MAX;
          else if (w_q == '0) begin
            if (!SAT) begin w_tgt = MAX; w_wrap_nxt = 1'b1; end
          end else               w_tgt = w_q - WIDTH'(1);
        end
        2'b10: begin
          // Gray walks the full 2**WIDTH code space regardless of MODULUS
          if (w_bin == ONES) begin
            if (!SAT) begin w_tgt = '0; w_wrap_nxt = 1'b1; end
          end else               w_tgt = bin2gray(w_bin + WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

  // P=target sets 0->1 and keeps 1s; N=target&Q keeps held 1s, so unchanged bits never toggle
  assign w_p = w_tgt;
  assign w_n = w_tgt & w_q;

  pn_flop u_bit [WIDTH-1:0] (
    .i_clk  (clk),
    .i_reset(reset),
    .i_p    (w_p),
    .i_n    (w_n),
    .o_q    (w_q)
  );

  always_ff @(posedge clk) begin
    if (reset) r_wrap <= 1'b0;
    else       r_wrap <= w_wrap_nxt;
  end

  always_comb begin
    case (bus.mode)
      2'b00:   bus.tc = (w_q == MAX);
      2'b01:   bus.tc = (w_q == '0);
      2'b10:   bus.tc = (w_q == G_LAST);
      default: bus.tc = 1'b0;
    endcase
  end

  assign bus.count = w_q;
  assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_pn_counter_n.sv
// Bench: wrapping and saturating 4-bit mod-10 counters driven in lockstep against an arithmetic model.
module tb_pn_counter_n;
  localparam int W = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pn_counter_n_if #(.WIDTH(W)) ifa ();
  pn_counter_n_if #(.WIDTH(W)) ifb ();

  pn_counter_n #(.WIDTH(W), .MODULUS(M), .SATURATE(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  pn_counter_n #(.WIDTH(W), .MODULUS(M), .SATURATE(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int checks = 0;
  int passes = 0;
  int mc[2];
  bit mw[2];
  int cur_mode = 0;

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int x = g; x != 0; x = x >> 1) b = b ^ x;
    return b;
  endfunction

  function automatic int exp_tc(input int c, input int md);
    case (md)
      0: return (c == M-1) ? 1 : 0;
      1: return (c == 0) ? 1 : 0;
      2: return (c == b2g(2**W - 1)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic ref_step(input int k, input bit sat, input bit rs, input bit en,
                          input bit ld, input int lv, input int md);
    int c = mc[k];
    int nc = c;
    bit w = 0;
    if (rs) nc = 0;
    else if (ld) nc = (lv >= M) ? M-1 : lv;
    else if (en && md == 0) begin
      if (c >= M) nc = 0;
      else if (c == M-1) begin nc = sat ? c : 0; w = !sat; end
      else nc = c + 1;
    end else if (en && md == 1) begin
      if (c >= M) nc = M-1;
      else if (c == 0) begin nc = sat ? 0 : M-1; w = !sat; end
      else nc = c - 1;
    end else if (en && md == 2) begin
      if (g2b(c) == 2**W - 1) begin nc = sat ? c : 0; w = !sat; end
      else nc = b2g(g2b(c) + 1);
    end
    mc[k] = nc;
    mw[k] = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input bit rs, input bit en, input bit ld, input int lv, input int md);
    reset = rs;
    ifa.en = en; ifa.load = ld; ifa.load_val = W'(lv); ifa.mode = 2'(md);
    ifb.en = en; ifb.load = ld; ifb.load_val = W'(lv); ifb.mode = 2'(md);
    cur_mode = md;
    @(posedge clk);
    #1;
    ref_step(0, 1'b0, rs, en, ld, lv, md);
    ref_step(1, 1'b1, rs, en, ld, lv, md);
    chk("a_count", 32'(ifa.count), 32'(mc[0]));
    chk("a_wrap",  32'(ifa.wrap),  32'(mw[0]));
    chk("a_tc",    32'(ifa.tc),    32'(exp_tc(mc[0], md)));
    chk("b_count", 32'(ifb.count), 32'(mc[1]));
    chk("b_wrap",  32'(ifb.wrap),  32'(mw[1]));
    chk("b_tc",    32'(ifb.tc),    32'(exp_tc(mc[1], md)));
  endtask

  int gseq[16] = '{1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0};
  logic [W-1:0] prev;

  initial begin
    mc = '{0, 0};
    mw = '{0, 0};
    step(1, 1, 1, 5, 0);
    chk("reset_count", 32'(ifa.count), 32'd0);
    chk("reset_wrap",  32'(ifa.wrap),  32'd0);

    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, 0, 0);
      chk("up_seq", 32'(ifa.count), 32'((k + 1) % 10));
      chk("up_wrap", 32'(ifa.wrap), 32'(k == 9));
    end
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 1);
      chk("down_seq", 32'(ifa.count), 32'(9 - k));
      chk("down_wrap", 32'(ifa.wrap), 32'(k == 0));
    end

    step(0, 1, 1, 7, 0);
    chk("load7", 32'(ifa.count), 32'd7);
    step(0, 1, 1, 12, 0);
    chk("load_clamp", 32'(ifa.count), 32'd9);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 3);
    chk("hold", 32'(ifa.count), 32'd9);

    step(0, 0, 1, 8, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
    chk("sat_up", 32'(ifb.count), 32'd9);
    step(0, 0, 1, 1, 1);
    for (int k = 0; k < 2; k++) step(0, 1, 0, 0, 1);
    chk("sat_down", 32'(ifb.count), 32'd0);

    step(1, 0, 0, 0, 2);
    for (int k = 0; k < 16; k++) begin
      prev = ifa.count;
      step(0, 1, 0, 0, 2);
      chk("gray_seq", 32'(ifa.count), 32'(gseq[k]));
      chk("gray_onebit", 32'($countones(prev ^ ifa.count)), 32'd1);
    end
    chk("gray_wrap", 32'(ifa.wrap), 32'd1);

    step(0, 0, 1, 4, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 3, 0);
    chk("reset_prio", 32'(ifa.count), 32'd0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("resume", 32'(ifa.count), 32'd2);

    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pn_counter_n.md
Name: pn_counter_n

Overview:
- Parametrised N-bit synchronous counter whose every state bit is a PN flip-flop.
- PN rule per bit: next = (P & ~Q) | (N & Q).
- Generalises the 2-bit PN-flop sequencer with:
  - configurable width and modulus;
  - up, down, Gray and hold modes;
  - parallel load;
  - optional saturation;
  - terminal-count and wrap outputs.
- Used as the general sequencer/timer primitive in lab datapaths.

Parameters:
WIDTH, 4, number of state bits (>=2)
MODULUS, 2**WIDTH, binary count range 0..MODULUS-1 (2..2**WIDTH)
SATURATE, 0, 1 = stop at end of range instead of wrapping (binary modes and Gray)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable
load  input  1  parallel load strobe
load_val  input  WIDTH  value captured on load
mode  input  2  00 up binary, 01 down binary, 10 up Gray, 11 hold
count  output  WIDTH  current state (PN-flop outputs)
tc  output  1  terminal count, combinational
wrap  output  1  registered one-cycle wrap pulse

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on rising clk only.
- State elements:
  - each count bit i is a PN flop, and the implementation must keep this structure;
  - P_i = 1 iff bit i must go 0->1 or the target value of bit i is 1;
  - N_i = 1 iff target bit i is 1 while Q_i = 1.
  - A bit whose target equals Q_i must not toggle.
- Reset: count = 0, wrap = 0 on the edge where reset = 1; overrides load and en.
- Priority per edge: reset > load > en > hold.
- Load:
  - count <= load_val, or MODULUS-1 if load_val >= MODULUS (clamp applies in all modes);
  - wrap <= 0; load is independent of en and mode.
- en=1, mode 00 (up binary):
  - count < MODULUS-1: count+1;
  - count == MODULUS-1: 0 with wrap <= 1, or hold if SATURATE=1 (wrap <= 0);
  - count >= MODULUS (possible after Gray mode): 0, wrap <= 0.
- en=1, mode 01 (down binary):
  - count > 0 and < MODULUS: count-1;
  - count == 0: MODULUS-1 with wrap <= 1, or hold if SATURATE=1;
  - count >= MODULUS: MODULUS-1, wrap <= 0.
- en=1, mode 10 (up Gray):
  - b = gray2bin(count); count <= bin2gray((b+1) mod 2**WIDTH); MODULUS is ignored;
  - b == 2**WIDTH-1: wraps to 0 with wrap <= 1, or holds if SATURATE=1;
  - exactly one bit changes per step.
- mode 11, or en=0: count holds, wrap <= 0.
- Mode change takes effect on the next enabled edge; no reset of count on mode change.
- tc (combinational, from current count and mode):
  - 00: count == MODULUS-1;
  - 01: count == 0;
  - 10: count == bin2gray(2**WIDTH-1);
  - 11: 0;
  - tc is independent of en.
- wrap:
  - high for exactly one cycle: the cycle count shows the wrapped value;
  - never high with SATURATE=1 or after a load/reset edge.
- Arithmetic is WIDTH-bit unsigned; no X/Z may reach count for any input combination after reset.

Test Plan:
1. WIDTH=4, MODULUS=10, reset, mode=00, en=1 for 12 edges -> count 1..9,0,1,2. tc=1 exactly while count=9. wrap=1 only in the cycle count=0 after 9.
2. Same instance, count=0, mode=01, en=1 for 3 edges -> count 9,8,7. wrap=1 only in the cycle showing 9. tc=1 while count=0.
3. load=1, en=1, load_val=7 -> count=7, wrap=0. load_val=12 -> count=9. Then mode=11, en=1 for 4 edges -> count stays 9, tc=0.
4. SATURATE=1, MODULUS=10, up from 8 with 3 enabled edges -> 9,9,9, wrap never 1. Down from 1 -> 0,0, wrap 0.
5. WIDTH=4, mode=10 from reset, 16 edges -> 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. Exactly one bit change per step. tc=1 at 8. wrap=1 at the final 0.
6. Mid-count (count=5, up) assert reset with en=1, load=1, load_val=3 -> next count=0, wrap=0. Counting resumes 1,2 after reset drops.
